// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix framebuffer loader.
// Geometry defaults and pixel bit positions within a received data byte.
package matrix_pkg;

    localparam int ADDR_W       = 10;
    localparam int FRAME_PIXELS = 1024;

    localparam int PIX_R = 0;
    localparam int PIX_G = 1;
    localparam int PIX_B = 2;

    typedef enum logic [1:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA
    } loader_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin with edge pulses.
// Edge pulses are one clk wide and aligned with the synchronised level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic              prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr   <= '0;
            prev <= 1'b0;
        end else begin
            sr   <= {sr[STAGES-2:0], din};
            prev <= sr[STAGES-1];
        end
    end

    assign sync = sr[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that turns an address header plus pixel bytes
// into single-cycle framebuffer write strobes in the clk domain.
module spi_frame_loader #(
    parameter int ADDR_W       = matrix_pkg::ADDR_W,
    parameter int FRAME_PIXELS = matrix_pkg::FRAME_PIXELS,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sck,
    input  logic              sdi,
    input  logic              cs_n,
    output logic              we,
    output logic [ADDR_W-1:0] adr_out,
    output logic              R_out,
    output logic              G_out,
    output logic              B_out,
    output logic              frame_done,
    output logic              overrun,
    output logic              busy
);

    import matrix_pkg::*;

    localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W+1)'(FRAME_PIXELS - 1);

    loader_state_t state, state_nx;

    logic             sck_rise;
    logic [1:0]       sck_unused;
    logic             cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] sdi_sr;
    logic             sdi_s;

    logic [2:0]       bit_cnt;
    logic [6:0]       shift;
    logic [7:0]       rx_byte;
    logic [ADDR_W:0]  addr;
    logic [ADDR_W:0]  pix_cnt;
    logic             wr_pend;
    logic             done_pend;

    logic active, bit_en, byte_done, pix_ok, pix_drop;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sck),
        .sync    (sck_unused[1]),
        .rise    (sck_rise),
        .fall    (sck_unused[0])
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (cs_n),
        .sync    (cs_s),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) sdi_sr <= '0;
        else          sdi_sr <= {sdi_sr[SYNC_STAGES-2:0], sdi};
    end

    assign sdi_s = sdi_sr[SYNC_STAGES-1];

    // sck and sdi share the same sync depth, so the sampled bit lines up
    assign active    = (state != IDLE) && !cs_s;
    assign bit_en    = active && sck_rise;
    assign byte_done = bit_en && (bit_cnt == 3'd7);
    assign rx_byte   = {shift, sdi_s};
    assign pix_ok    = byte_done && (state == DATA) && (addr <= LAST_PIX);
    assign pix_drop  = byte_done && (state == DATA) && (addr > LAST_PIX);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cs_fall)        state_nx = ADDR_HI;
            ADDR_HI: if (cs_rise)        state_nx = IDLE;
                     else if (byte_done) state_nx = ADDR_LO;
            ADDR_LO: if (cs_rise)        state_nx = IDLE;
                     else if (byte_done) state_nx = DATA;
            DATA:    if (cs_rise)        state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            shift      <= '0;
            addr       <= '0;
            pix_cnt    <= '0;
            wr_pend    <= 1'b0;
            done_pend  <= 1'b0;
            we         <= 1'b0;
            adr_out    <= '0;
            R_out      <= 1'b0;
            G_out      <= 1'b0;
            B_out      <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            we         <= wr_pend;
            wr_pend    <= pix_ok;
            frame_done <= 1'b0;

            if (bit_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= rx_byte[6:0];
            end else if (!active) begin
                bit_cnt <= '0;
            end

            if (state == IDLE && cs_fall) begin
                overrun <= 1'b0;
                pix_cnt <= '0;
            end

            if (byte_done && state == ADDR_HI)
                addr[ADDR_W:8] <= {1'b0, rx_byte[ADDR_W-9:0]};
            if (byte_done && state == ADDR_LO)
                addr[7:0] <= rx_byte;

            // outputs stay put until the next accepted pixel
            if (pix_ok) begin
                adr_out <= addr[ADDR_W-1:0];
                R_out   <= rx_byte[PIX_R];
                G_out   <= rx_byte[PIX_G];
                B_out   <= rx_byte[PIX_B];
                addr    <= addr + 1'b1;
                pix_cnt <= pix_cnt + 1'b1;
            end

            if (pix_drop) overrun <= 1'b1;

            if (cs_rise && state != IDLE && pix_cnt != '0) begin
                done_pend <= 1'b1;
            end else if (done_pend && !wr_pend) begin
                done_pend  <= 1'b0;
                frame_done <= 1'b1;
            end
        end
    end

endmodule
